// File: rtl/sum_acc.sv
// Streaming accumulator: sums acc_len_i operands arriving on a valid/ready
// input channel and presents the total on a valid/ready output channel.
module sum_acc #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc_start_i,
  input  logic [CNT_W-1:0] acc_len_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] len_q,   len_d;

  logic             in_fire;
  logic             out_fire;
  logic [CNT_W-1:0] cnt_inc;

  assign in_fire  = in_valid_i  && in_ready_o;
  assign out_fire = out_valid_o && out_ready_i;
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // Next-state and datapath update.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    len_d   = len_q;

    unique case (state_q)
      IDLE: begin
        if (acc_start_i) begin
          sum_d = '0;
          cnt_d = '0;
          len_d = acc_len_i;
          // A zero-length job skips ACC and reports the cleared sum.
          state_d = (acc_len_i == '0) ? DONE : ACC;
        end
      end

      ACC: begin
        if (in_fire) begin
          sum_d = sum_q + in_data_i;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (out_fire) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_o = 1'b0;
      end
      ACC: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b1;
      end
      DONE: begin
        out_valid_o = 1'b1;
        busy_o      = 1'b1;
      end
      default: begin
        busy_o = 1'b1;
      end
    endcase
  end

  assign out_data_o = sum_q;

endmodule

// File: tb/tb_sum_acc.sv
// Directed bench for sum_acc: each job pushes its expected total to a
// scoreboard queue at start and pops it when the result is presented.
module tb_sum_acc;

  localparam int WIDTH = 64;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             acc_start_i;
  logic [CNT_W-1:0] acc_len_i;
  logic             in_valid_i;
  logic [WIDTH-1:0] in_data_i;
  logic             in_ready_o;
  logic             out_valid_o;
  logic [WIDTH-1:0] out_data_o;
  logic             out_ready_i;
  logic             busy_o;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] op_q[$];
  bit               vld_q[$];

  sum_acc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .acc_start_i (acc_start_i),
    .acc_len_i   (acc_len_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  WIDTH'(in_ready_o),  '0);
    check({tag, "_out_valid"}, WIDTH'(out_valid_o), '0);
    check({tag, "_out_data"},  out_data_o,          '0);
    check({tag, "_busy"},      WIDTH'(busy_o),      '0);
  endtask

  // Runs one job from IDLE using op_q/vld_q as the per-cycle input pattern.
  // Invalid slots carry junk data that must not reach the sum. When poke is
  // set, a conflicting start request is raised on every gap cycle in ACC.
  task automatic run_job(input int len, input int stall, input bit poke);
    logic [WIDTH-1:0] exp_sum;
    logic [WIDTH-1:0] exp_val;
    int               taken;
    exp_sum = '0;
    taken   = 0;
    foreach (op_q[i]) begin
      if (vld_q[i] && taken < len) begin
        exp_sum = exp_sum + op_q[i];
        taken++;
      end
    end
    exp_q.push_back(exp_sum);

    acc_start_i = 1'b1;
    acc_len_i   = CNT_W'(len);
    @(posedge clk); #1;
    acc_start_i = 1'b0;
    acc_len_i   = '1;
    check("busy_after_start", WIDTH'(busy_o), 1);

    taken = 0;
    if (len != 0) begin
      for (int i = 0; i < vld_q.size() && taken < len; i++) begin
        check("acc_in_ready",  WIDTH'(in_ready_o),  1);
        check("acc_out_valid", WIDTH'(out_valid_o), 0);
        check("acc_busy",      WIDTH'(busy_o),      1);
        in_valid_i  = vld_q[i];
        in_data_i   = op_q[i];
        acc_start_i = poke && !vld_q[i];
        acc_len_i   = CNT_W'(len + 5);
        @(posedge clk); #1;
        if (vld_q[i]) taken++;
      end
      in_valid_i  = 1'b0;
      in_data_i   = '0;
      acc_start_i = 1'b0;
    end

    // One cycle after the final transfer the result must be presented.
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      exp_val = '0;
    end else begin
      exp_val = exp_q.pop_front();
    end
    check("done_out_valid", WIDTH'(out_valid_o), 1);
    check("done_in_ready",  WIDTH'(in_ready_o),  0);
    check("done_out_data",  out_data_o,          exp_val);

    out_ready_i = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_out_valid", WIDTH'(out_valid_o), 1);
      check("stall_out_data",  out_data_o,          exp_val);
    end

    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    check("post_out_valid", WIDTH'(out_valid_o), 0);
    check("post_busy",      WIDTH'(busy_o),      0);
  endtask

  initial begin
    rst_n       = 1'b0;
    acc_start_i = 1'b0;
    acc_len_i   = '0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b0;

    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic back-to-back sum of 1..4.
    op_q  = '{64'd1, 64'd2, 64'd3, 64'd4};
    vld_q = '{1'b1, 1'b1, 1'b1, 1'b1};
    run_job(4, 0, 1'b0);

    // Wrap-around: all-ones + 2 drops the carry; output held through a stall.
    op_q  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h2};
    vld_q = '{1'b1, 1'b1};
    run_job(2, 5, 1'b0);

    // Gaps on the input; junk on invalid slots plus ignored start pokes.
    op_q  = '{64'd100, 64'hDEAD_BEEF, 64'hCAFE, 64'd20, 64'h1234_5678, 64'd3};
    vld_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_job(3, 2, 1'b1);

    // Zero length goes straight to DONE with a cleared sum.
    op_q  = '{};
    vld_q = '{};
    run_job(0, 1, 1'b0);

    // Reset mid-accumulation after two of five operands.
    acc_start_i = 1'b1;
    acc_len_i   = CNT_W'(5);
    @(posedge clk); #1;
    acc_start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = WIDTH'(i + 50);
      @(posedge clk); #1;
    end
    check("mid_busy", WIDTH'(busy_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    in_valid_i = 1'b0;
    in_data_i  = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First start after reset must be taken on the very next edge.
    op_q  = '{64'd7};
    vld_q = '{1'b1};
    run_job(1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
